// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types: data word, ALU opcode, flag bit positions and
//            the arbiter FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int c_word_w = 32;
    localparam int c_op_w   = 4;

    typedef logic [c_word_w-1:0] word_t;

    typedef enum logic [c_op_w-1:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Bit positions inside the packed {negative, zero, overflow} flag field
    localparam int FLG_NEG  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_OVF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin picker; searches from ptr+1 upward
//            (wrapping) and returns a one-hot grant plus its index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] w_slot;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_slot = ptr;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap keeps non-power-of-two NREQ inside the vector
            w_slot = (w_slot == IDX_W'(NREQ - 1)) ? '0 : w_slot + 1'b1;
            if (!any && req[w_slot]) begin
                any         = 1'b1;
                gnt[w_slot] = 1'b1;
                idx         = w_slot;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between NREQ
//            requesters; latches operands, registers and holds the result.
//            Optional counters enabled by ALU_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WORD_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*OP_W-1:0]     req_op,
    input  logic [NREQ*WORD_W-1:0]   req_a,
    input  logic [NREQ*WORD_W-1:0]   req_b,
    output logic [NREQ-1:0]          gnt,
    output logic [OP_W-1:0]          alu_op,
    output logic [WORD_W-1:0]        alu_porta,
    output logic [WORD_W-1:0]        alu_portb,
    input  logic [WORD_W-1:0]        alu_out,
    input  logic                     alu_neg,
    input  logic                     alu_zero,
    input  logic                     alu_ovf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WORD_W-1:0]        rsp_data,
    output logic [2:0]               rsp_flags,
`ifdef ALU_ARBITER_STATS_EN
    output logic [15:0]              stat_ops,
    output logic [15:0]              stat_ovf,
`endif
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_ptr, r_id, r_rsp_id;
    logic [OP_W-1:0]   r_op, w_sel_op;
    logic [WORD_W-1:0] r_a, r_b, w_sel_a, w_sel_b, r_rsp_data;
    logic [2:0]        r_rsp_flags, w_flags;
    logic              r_rsp_valid;
    logic [NREQ-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any, w_take, w_exec, w_accept;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_exec      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_pick_any) begin
                w_take      = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: if (rsp_ready) begin
                w_accept    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // gnt is the combinational pick; masking with nRST keeps it quiet in reset
    always_comb begin
        gnt      = (w_take && nRST) ? w_pick_gnt : '0;
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_sel_op = req_op[i*OP_W +: OP_W];
                w_sel_a  = req_a[i*WORD_W +: WORD_W];
                w_sel_b  = req_b[i*WORD_W +: WORD_W];
            end
        end
        w_flags           = '0;
        w_flags[FLG_NEG]  = alu_neg;
        w_flags[FLG_ZERO] = alu_zero;
        w_flags[FLG_OVF]  = alu_ovf;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDX_W'(NREQ - 1);
            r_id        <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_ptr <= w_pick_idx;
                r_id  <= w_pick_idx;
                r_op  <= w_sel_op;
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
            end
            if (w_exec) begin
                r_rsp_data  <= alu_out;
                r_rsp_flags <= w_flags;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] r_stat_ops, r_stat_ovf;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_ops <= '0;
            r_stat_ovf <= '0;
        end else if (w_exec) begin
            if (r_stat_ops != 16'hFFFF) r_stat_ops <= r_stat_ops + 16'd1;
            if (alu_ovf && r_stat_ovf != 16'hFFFF) r_stat_ovf <= r_stat_ovf + 16'd1;
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_ovf = r_stat_ovf;
`endif

    // ALU drive holds the latched operands in every state to avoid toggling
    assign alu_op    = r_op;
    assign alu_porta = r_a;
    assign alu_portb = r_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter (NREQ=4) with a behavioural
//            ALU and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ     = 4;
    localparam int WORD_W   = 32;
    localparam int OP_W     = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_WAIT = 20;

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] res;
    } txn_t;

    logic                     CLK  = 1'b0;
    logic                     nRST = 1'b0;
    logic [NREQ-1:0]          req  = '0;
    logic [NREQ*OP_W-1:0]     req_op = '0;
    logic [NREQ*WORD_W-1:0]   req_a  = '0;
    logic [NREQ*WORD_W-1:0]   req_b  = '0;
    logic [NREQ-1:0]          gnt;
    logic [OP_W-1:0]          alu_op;
    logic [WORD_W-1:0]        alu_porta, alu_portb, alu_out;
    logic                     alu_neg, alu_zero, alu_ovf;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [IDX_W-1:0]         rsp_id;
    logic [WORD_W-1:0]        rsp_data;
    logic [2:0]               rsp_flags;
    logic                     busy;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]              stat_ops, stat_ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .alu_op    (alu_op),
        .alu_porta (alu_porta),
        .alu_portb (alu_portb),
        .alu_out   (alu_out),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
`ifdef ALU_ARBITER_STATS_EN
        .stat_ops  (stat_ops),
        .stat_ovf  (stat_ovf),
`endif
        .busy      (busy)
    );

    // Shared ALU as seen by the arbiter: purely combinational
    always_comb begin
        alu_out = alu_porta;
        alu_ovf = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_out = alu_porta + alu_portb;
                alu_ovf = (alu_porta[31] == alu_portb[31]) && (alu_out[31] != alu_porta[31]);
            end
            ALU_SUB: begin
                alu_out = alu_porta - alu_portb;
                alu_ovf = (alu_porta[31] != alu_portb[31]) && (alu_out[31] != alu_porta[31]);
            end
            ALU_AND: alu_out = alu_porta & alu_portb;
            ALU_OR:  alu_out = alu_porta | alu_portb;
            ALU_XOR: alu_out = alu_porta ^ alu_portb;
            default: alu_out = alu_porta;
        endcase
        alu_neg  = alu_out[31];
        alu_zero = (alu_out == 32'd0);
    end

    // Reference result {data, neg, zero, ovf} from wide signed arithmetic
    function automatic logic [34:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, r;
        logic [31:0] d;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        v  = 1'b0;
        d  = a;
        case (op)
            4'd2: begin r = sa + sb; d = r[31:0]; v = (r != longint'($signed(d))); end
            4'd3: begin r = sa - sb; d = r[31:0]; v = (r != longint'($signed(d))); end
            4'd4: d = a & b;
            4'd5: d = a | b;
            4'd6: d = a ^ b;
            default: d = a;
        endcase
        return {d, d[31], (d == 32'd0), v};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] rq, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (rq[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_slot(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[i*OP_W +: OP_W]     = op;
        req_a[i*WORD_W +: WORD_W]  = a;
        req_b[i*WORD_W +: WORD_W]  = b;
    endtask

    task automatic rand_slot(input int i);
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom);
        case ($urandom_range(0, 4))
            0:       b = a;
            1:       b = 32'h80000000;
            2:       b = 32'd1;
            default: b = 32'($urandom);
        endcase
        set_slot(i, 4'($urandom_range(2, 6)), a, b);
    endtask

    task automatic drain();
        int n;
        req = '0;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < MAX_WAIT) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout: busy=%b required 0", busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        req  = '1;
        for (int i = 0; i < NREQ; i++) rand_slot(i);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b valid=%b required 0/0/0", gnt, busy, rsp_valid);
        end
        vectors++;
        if (rsp_data !== '0 || rsp_flags !== '0 || rsp_id !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: data=%h flags=%b id=%0d required zeros", rsp_data, rsp_flags, rsp_id);
        end
        vectors++;
        if (alu_op !== '0 || alu_porta !== '0 || alu_portb !== '0) begin
            miscompares++;
            $display("FAIL reset_alu: op=%h a=%h b=%h required zeros", alu_op, alu_porta, alu_portb);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_gnt: gnt=%b required 0001", gnt);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_single();
        @(posedge CLK); #1;
        set_slot(0, ALU_ADD, 32'd5, 32'd7);
        req = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_gnt: gnt=%b required 0001", gnt);
        end
        @(posedge CLK); #1;
        req = '0;
        @(negedge CLK);
        vectors++;
        if (gnt !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_exec: gnt=%b busy=%b valid=%b required 0000/1/0", gnt, busy, rsp_valid);
        end
        vectors++;
        if (alu_op !== ALU_ADD || alu_porta !== 32'd5 || alu_portb !== 32'd7) begin
            miscompares++;
            $display("FAIL single_alu_drive: op=%h a=%h b=%h required 2/5/7", alu_op, alu_porta, alu_portb);
        end
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 2'd0 || rsp_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL single_rsp: valid=%b data=%h id=%0d flags=%b required 1/c/0/000",
                     rsp_valid, rsp_data, rsp_id, rsp_flags);
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept: busy=%b valid=%b required 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_zero_backpressure();
        @(posedge CLK); #1;
        set_slot(1, ALU_SUB, 32'd3, 32'd3);
        req = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL zero_gnt: gnt=%b required 0010", gnt);
        end
        @(posedge CLK); #1;
        set_slot(0, ALU_ADD, 32'd1, 32'd1);
        req = 4'b0001;
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_flags !== 3'b010 || rsp_id !== 2'd1) begin
            miscompares++;
            $display("FAIL zero_rsp: valid=%b data=%h flags=%b id=%0d required 1/0/010/1",
                     rsp_valid, rsp_data, rsp_flags, rsp_id);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_flags !== 3'b010 ||
                rsp_id !== 2'd1 || gnt !== '0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_hold[%0d]: valid=%b data=%h flags=%b id=%0d gnt=%b busy=%b",
                         c, rsp_valid, rsp_data, rsp_flags, rsp_id, gnt, busy);
            end
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL zero_release: busy=%b valid=%b gnt=%b required 0/0/0001", busy, rsp_valid, gnt);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_overflow();
        @(posedge CLK); #1;
        set_slot(2, ALU_ADD, 32'h7FFFFFFF, 32'd1);
        req = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL ovf_gnt: gnt=%b required 0100", gnt);
        end
        @(posedge CLK); #1;
        req = '0;
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h80000000 || rsp_flags !== 3'b101 || rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL ovf_rsp: valid=%b data=%h flags=%b id=%0d required 1/80000000/101/2",
                     rsp_valid, rsp_data, rsp_flags, rsp_id);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_fairness();
        int seen, cyc, last_cyc;
        logic [NREQ-1:0] exp_g;
        // Last grant so far went to requester 2: two-way order is 0,1,0,1
        @(posedge CLK); #1;
        for (int i = 0; i < NREQ; i++) rand_slot(i);
        req = 4'b0011;
        rsp_ready = 1'b1;
        seen = 0; cyc = 0; last_cyc = 0;
        while (seen < 4 && cyc < 40) begin
            @(negedge CLK);
            if (gnt !== '0) begin
                exp_g = (seen % 2 == 0) ? 4'b0001 : 4'b0010;
                vectors++;
                if (gnt !== exp_g) begin
                    miscompares++;
                    $display("FAIL fair2_order[%0d]: gnt=%b required %b", seen, gnt, exp_g);
                end
                if (seen > 0) begin
                    vectors++;
                    if (cyc - last_cyc != 3) begin
                        miscompares++;
                        $display("FAIL fair2_spacing[%0d]: %0d cycles required 3", seen, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                seen++;
            end
            cyc++;
        end
        vectors++;
        if (seen != 4) begin
            miscompares++;
            $display("FAIL fair2_timeout: grants=%0d required 4", seen);
        end
        // Four-way after last grant to 1: order 2,3,0,1,2
        @(posedge CLK); #1;
        req = 4'b1111;
        seen = 0; cyc = 0; last_cyc = 0;
        while (seen < 5 && cyc < 60) begin
            @(negedge CLK);
            if (gnt !== '0) begin
                exp_g = 4'b0001 << ((2 + seen) % 4);
                vectors++;
                if (gnt !== exp_g) begin
                    miscompares++;
                    $display("FAIL fair4_order[%0d]: gnt=%b required %b", seen, gnt, exp_g);
                end
                if (seen > 0) begin
                    vectors++;
                    if (cyc - last_cyc != 3) begin
                        miscompares++;
                        $display("FAIL fair4_spacing[%0d]: %0d cycles required 3", seen, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                seen++;
            end
            cyc++;
        end
        vectors++;
        if (seen != 5) begin
            miscompares++;
            $display("FAIL fair4_timeout: grants=%0d required 5", seen);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_reset_mid_exec();
        @(posedge CLK); #1;
        set_slot(3, ALU_XOR, 32'hDEADBEEF, 32'h12345678);
        req = 4'b1000;
        rsp_ready = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL midrst_gnt: gnt=%b required 1000", gnt);
        end
        @(posedge CLK); #1;
        req = 4'b1111;
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== '0 || rsp_data !== '0 ||
            rsp_flags !== '0 || rsp_id !== '0 || alu_porta !== '0 || alu_portb !== '0 || alu_op !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: busy=%b valid=%b gnt=%b data=%h flags=%b id=%0d a=%h b=%h op=%h",
                     busy, rsp_valid, gnt, rsp_data, rsp_flags, rsp_id, alu_porta, alu_portb, alu_op);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (gnt !== 4'b0001 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_after: gnt=%b busy=%b valid=%b required 0001/0/0", gnt, busy, rsp_valid);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_random();
        txn_t            q[$];
        txn_t            t;
        int              last, age, k;
        bit              outstanding, g_seen, hs_seen;
        logic [NREQ-1:0] g_vec, exp_g;
        logic            exp_valid;
        req = '0;
        rsp_ready = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        last = NREQ - 1;
        outstanding = 1'b0; g_seen = 1'b0; hs_seen = 1'b0; age = 0; g_vec = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge CLK); #1;
            if (g_seen) begin
                outstanding = 1'b1;
                age = 0;
            end else if (outstanding) begin
                if (hs_seen) begin
                    outstanding = 1'b0;
                    void'(q.pop_front());
                end else begin
                    age++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g_seen && g_vec[i]) begin
                    rand_slot(i);
                    req[i] = ($urandom_range(0, 3) == 0);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rand_slot(i);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge CLK);
            exp_g = '0;
            k = -1;
            if (!outstanding) begin
                k = rr_pick(req, last);
                if (k >= 0) exp_g[k] = 1'b1;
            end
            exp_valid = outstanding && (age >= 1);
            vectors++;
            if (gnt !== exp_g) begin
                miscompares++;
                $display("FAIL rand_gnt c%0d: gnt=%b required %b", c, gnt, exp_g);
            end
            vectors++;
            if (busy !== outstanding || rsp_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL rand_state c%0d: busy=%b valid=%b required %b/%b", c, busy, rsp_valid, outstanding, exp_valid);
            end
            if (outstanding && age == 0 && q.size() > 0) begin
                vectors++;
                if (alu_op !== q[0].op || alu_porta !== q[0].a || alu_portb !== q[0].b) begin
                    miscompares++;
                    $display("FAIL rand_alu c%0d: op=%h a=%h b=%h required %h/%h/%h",
                             c, alu_op, alu_porta, alu_portb, q[0].op, q[0].a, q[0].b);
                end
            end
            if (exp_valid && q.size() > 0) begin
                vectors++;
                if ({rsp_data, rsp_flags} !== q[0].res || int'(rsp_id) != q[0].id) begin
                    miscompares++;
                    $display("FAIL rand_rsp c%0d: data=%h flags=%b id=%0d required %h/%b/%0d",
                             c, rsp_data, rsp_flags, rsp_id, q[0].res[34:3], q[0].res[2:0], q[0].id);
                end
            end
            g_seen  = (k >= 0);
            g_vec   = exp_g;
            hs_seen = exp_valid && rsp_ready;
            if (g_seen) begin
                t.id  = k;
                t.op  = req_op[k*OP_W +: OP_W];
                t.a   = req_a[k*WORD_W +: WORD_W];
                t.b   = req_b[k*WORD_W +: WORD_W];
                t.res = model_alu(t.op, t.a, t.b);
                q.push_back(t);
                last  = k;
            end
        end
        @(posedge CLK); #1;
        drain();
    endtask

`ifdef ALU_ARBITER_STATS_EN
    task automatic do_op(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge CLK); #1;
        set_slot(i, op, a, b);
        req = '0;
        req[i] = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge CLK);
        while (gnt[i] !== 1'b1 && n < MAX_WAIT) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (gnt[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL stats_gnt_timeout: gnt=%b required bit %0d", gnt, i);
        end
        @(posedge CLK); #1;
        drain();
    endtask

    task automatic test_stats();
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (stat_ops !== 16'd0 || stat_ovf !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset: ops=%0d ovf=%0d required 0/0", stat_ops, stat_ovf);
        end
        do_op(0, ALU_ADD, 32'd1, 32'd1);
        do_op(1, ALU_ADD, 32'h7FFFFFFF, 32'd1);
        do_op(2, ALU_SUB, 32'd5, 32'd2);
        vectors++;
        if (stat_ops !== 16'd3 || stat_ovf !== 16'd1) begin
            miscompares++;
            $display("FAIL stats_count: ops=%0d ovf=%0d required 3/1", stat_ops, stat_ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero_backpressure();
        test_overflow();
        test_fairness();
        test_reset_mid_exec();
        test_random();
`ifdef ALU_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
